// File: rtl/rf_pkg.sv
// Shared register-file constants and helpers, used by both the issue frontend
// and the backend register file.
package rf_pkg;

    localparam int          RF_XLEN     = 32;
    localparam int          RF_NUM_REGS = 32;
    localparam int          RF_SP_INDEX = 2;
    localparam logic [31:0] RF_SP_RESET = 32'h0200_0000;

    // Index width is always derived from the register count, never set directly.
    function automatic int rf_aw(input int num_regs);
        return $clog2(num_regs);
    endfunction

    // Low bit of port `port` inside a packed multi-port bus of `width`-bit lanes.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle between issue/writeback and the multi-port register file.
interface regfile_mp_if #(
    parameter int XLEN      = rf_pkg::RF_XLEN,
    parameter int NUM_REGS  = rf_pkg::RF_NUM_REGS,
    parameter int NUM_READ  = 4,
    parameter int NUM_WRITE = 2
);
    import rf_pkg::*;

    localparam int AW = rf_aw(NUM_REGS);

    logic [NUM_READ*AW-1:0]    rd_index;
    logic [NUM_READ*XLEN-1:0]  rd_data;
    logic [NUM_READ-1:0]       rd_ready;
    logic [NUM_WRITE-1:0]      wr_en;
    logic [NUM_WRITE*AW-1:0]   wr_index;
    logic [NUM_WRITE*XLEN-1:0] wr_data;
    logic                      alloc_en;
    logic [AW-1:0]             alloc_index;
    logic                      flush;
    logic [NUM_REGS-1:0]       busy_vec;

    modport master (
        output rd_index, wr_en, wr_index, wr_data, alloc_en, alloc_index, flush,
        input  rd_data, rd_ready, busy_vec
    );

    modport slave (
        input  rd_index, wr_en, wr_index, wr_data, alloc_en, alloc_index, flush,
        output rd_data, rd_ready, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: writes clear, alloc sets, flush clears everything.
// Also provides the raw pending lookup for each read port.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int NUM_READ  = 4,
    parameter int NUM_WRITE = 2,
    localparam int AW       = rf_aw(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WRITE-1:0]    wr_en,
    input  logic [NUM_WRITE*AW-1:0] wr_index,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_index,
    input  logic                    flush,
    input  logic [NUM_READ*AW-1:0]  rd_index,
    output logic [NUM_READ-1:0]     rd_pending,
    output logic [NUM_REGS-1:0]     busy_vec
);

    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Later steps override earlier ones: write-clear, then alloc, then flush.
    always_comb begin
        pending_next = pending_reg;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_en[j]) begin
                pending_next[wr_index[slice_lo(j, AW) +: AW]] = 1'b0;
            end
        end
        if (alloc_en && alloc_index != '0) begin
            pending_next[alloc_index] = 1'b1;
        end
        if (flush) begin
            pending_next = '0;
        end
        pending_next[0] = 1'b0;
    end

    assign busy_vec = pending_reg;

    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_lookup
        assign rd_pending[gi] = pending_reg[rd_index[gi*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through forwarding, reset
// values for the stack pointer, and an integrated pending scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int              XLEN      = RF_XLEN,
    parameter int              NUM_REGS  = RF_NUM_REGS,
    parameter int              NUM_READ  = 4,
    parameter int              NUM_WRITE = 2,
    parameter int              SP_INDEX  = RF_SP_INDEX,
    parameter logic [XLEN-1:0] SP_RESET  = RF_SP_RESET,
    localparam int             AW        = rf_aw(NUM_REGS)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    logic [XLEN-1:0]          regs_reg [NUM_REGS];
    logic [NUM_WRITE-1:0]     wr_act;
    logic [NUM_READ-1:0]      rd_pending;
    logic [NUM_READ*XLEN-1:0] rd_data_vec;
    logic [NUM_READ-1:0]      rd_ready_vec;

    // Writes must neither forward nor clear pending bits while reset is held.
    assign wr_act = rst ? '0 : bus.wr_en;

    rf_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_act),
        .wr_index    (bus.wr_index),
        .alloc_en    (bus.alloc_en),
        .alloc_index (bus.alloc_index),
        .flush       (bus.flush),
        .rd_index    (bus.rd_index),
        .rd_pending  (rd_pending),
        .busy_vec    (bus.busy_vec)
    );

    // Ascending port loop: the last non-blocking assignment (highest port) wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_reg[r] <= (r == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (bus.wr_en[j] && bus.wr_index[slice_lo(j, AW) +: AW] != '0) begin
                    regs_reg[bus.wr_index[slice_lo(j, AW) +: AW]] <=
                        bus.wr_data[slice_lo(j, XLEN) +: XLEN];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            fwd_hit;

        assign idx = bus.rd_index[gi*AW +: AW];

        always_comb begin
            data    = regs_reg[idx];
            fwd_hit = 1'b0;
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_act[j] && bus.wr_index[slice_lo(j, AW) +: AW] == idx) begin
                    data    = bus.wr_data[slice_lo(j, XLEN) +: XLEN];
                    fwd_hit = 1'b1;
                end
            end
            if (idx == '0) begin
                data    = '0;
                fwd_hit = 1'b1;
            end
        end

        assign rd_data_vec[gi*XLEN +: XLEN] = data;
        assign rd_ready_vec[gi]             = fwd_hit || !rd_pending[gi];
    end

    assign bus.rd_data  = rd_data_vec;
    assign bus.rd_ready = rd_ready_vec;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against a plain array model.
module tb_regfile_mp;

    localparam int NR = 4;
    localparam int NW = 2;

    logic clk;
    logic rst;

    regfile_mp_if bus ();

    regfile_mp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference state
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_rst;

    // Stimulus for the current cycle
    int          t_rd [NR];
    bit          t_we [NW];
    int          t_wi [NW];
    logic [31:0] t_wd [NW];
    bit          t_ae;
    int          t_ai;
    bit          t_fl;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = (r == 2) ? 32'h0200_0000 : 32'h0;
            m_pend[r] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input int k);
        int idx = t_rd[k];
        if (idx == 0) return 32'h0;
        if (!m_rst) begin
            for (int j = NW - 1; j >= 0; j--) begin
                if (t_we[j] && t_wi[j] == idx) return t_wd[j];
            end
        end
        return m_regs[idx];
    endfunction

    function automatic logic model_ready(input int k);
        int idx = t_rd[k];
        if (idx == 0 || m_rst || !m_pend[idx]) return 1'b1;
        for (int j = 0; j < NW; j++) begin
            if (t_we[j] && t_wi[j] == idx) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic model_commit();
        for (int j = 0; j < NW; j++) begin
            if (t_we[j] && t_wi[j] != 0) m_regs[t_wi[j]] = t_wd[j];
        end
        for (int j = 0; j < NW; j++) begin
            if (t_we[j]) m_pend[t_wi[j]] = 1'b0;
        end
        if (t_ae && t_ai != 0) m_pend[t_ai] = 1'b1;
        if (t_fl) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        end
    endtask

    task automatic apply();
        logic [NR*5-1:0]  ri;
        logic [NW-1:0]    we;
        logic [NW*5-1:0]  wi;
        logic [NW*32-1:0] wd;
        for (int k = 0; k < NR; k++) ri[k*5 +: 5] = t_rd[k][4:0];
        for (int j = 0; j < NW; j++) begin
            we[j]         = t_we[j];
            wi[j*5 +: 5]  = t_wi[j][4:0];
            wd[j*32 +: 32] = t_wd[j];
        end
        bus.rd_index    = ri;
        bus.wr_en       = we;
        bus.wr_index    = wi;
        bus.wr_data     = wd;
        bus.alloc_en    = t_ae;
        bus.alloc_index = t_ai[4:0];
        bus.flush       = t_fl;
    endtask

    task automatic idle();
        for (int j = 0; j < NW; j++) t_we[j] = 1'b0;
        t_ae = 1'b0;
        t_fl = 1'b0;
    endtask

    task automatic set_rd(input int a, input int b, input int c, input int d);
        t_rd[0] = a; t_rd[1] = b; t_rd[2] = c; t_rd[3] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("%s rd_data[%0d] idx=%0d", tag, k, t_rd[k]),
                bus.rd_data[k*32 +: 32], model_read(k));
            chk($sformatf("%s rd_ready[%0d] idx=%0d", tag, k, t_rd[k]),
                {31'h0, bus.rd_ready[k]}, {31'h0, model_ready(k)});
        end
        chk($sformatf("%s busy_vec", tag), bus.busy_vec, model_busy());
    endtask

    // One clocked transaction: drive, check combinational view, clock, update model.
    task automatic cycle(input string tag);
        apply();
        #2;
        check_all(tag);
        $display("txn %-12s rd=%0d/%0d/%0d/%0d we=%0d%0d wi=%0d/%0d ae=%0d ai=%0d fl=%0d",
                 tag, t_rd[0], t_rd[1], t_rd[2], t_rd[3], t_we[1], t_we[0],
                 t_wi[0], t_wi[1], t_ae, t_ai, t_fl);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        m_rst = 1'b0;
        set_rd(0, 0, 0, 0);
        for (int j = 0; j < NW; j++) begin
            t_we[j] = 1'b0; t_wi[j] = 0; t_wd[j] = '0;
        end
        t_ae = 1'b0; t_ai = 0; t_fl = 1'b0;
        apply();

        // Asynchronous reset before any clock edge
        #1;
        rst = 1'b1; m_rst = 1'b1;
        model_reset();
        set_rd(0, 2, 5, 9);
        apply();
        #1;
        check_all("reset");

        // Writes and allocs are ignored while reset is held, across an edge too
        t_we[0] = 1'b1; t_wi[0] = 5; t_wd[0] = 32'h1234_5678;
        t_we[1] = 1'b1; t_wi[1] = 9; t_wd[1] = 32'h8765_4321;
        t_ae = 1'b1; t_ai = 5;
        apply();
        #1;
        check_all("rst_ign_comb");
        @(posedge clk);
        #1;
        check_all("rst_ign_edge");
        idle();
        rst = 1'b0; m_rst = 1'b0;

        // Write-through forwarding, then persistence
        set_rd(5, 2, 0, 9);
        t_we[0] = 1'b1; t_wi[0] = 5; t_wd[0] = 32'hDEAD_BEEF;
        cycle("fwd");
        idle();
        cycle("persist");

        // Same-register collision: higher port wins
        set_rd(5, 7, 0, 2);
        t_we[0] = 1'b1; t_wi[0] = 7; t_wd[0] = 32'h11;
        t_we[1] = 1'b1; t_wi[1] = 7; t_wd[1] = 32'h22;
        cycle("collide");
        idle();
        cycle("collide_st");

        // Register 0 is never written
        t_we[1] = 1'b1; t_wi[1] = 0; t_wd[1] = 32'hFFFF_FFFF;
        set_rd(0, 7, 0, 5);
        cycle("r0_write");
        idle();
        cycle("r0_after");

        // Scoreboard: alloc, later write clears, same-cycle alloc beats write
        set_rd(9, 0, 7, 9);
        t_ae = 1'b1; t_ai = 9;
        cycle("alloc9");
        idle();
        cycle("pend9");
        t_we[0] = 1'b1; t_wi[0] = 9; t_wd[0] = 32'h99;
        cycle("wr9");
        idle();
        cycle("clr9");
        t_we[1] = 1'b1; t_wi[1] = 9; t_wd[1] = 32'h909;
        t_ae = 1'b1; t_ai = 9;
        cycle("alloc_wr9");
        idle();
        cycle("still9");

        // Flush overrides a same-cycle alloc
        set_rd(3, 4, 5, 6);
        t_ae = 1'b1;
        t_ai = 3; cycle("alloc3");
        t_ai = 4; cycle("alloc4");
        t_ai = 5; cycle("alloc5");
        t_ai = 6; t_fl = 1'b1;
        cycle("flush");
        idle();
        cycle("post_flush");

        // Randomized traffic; small index range half the time to provoke collisions
        for (int n = 0; n < 250; n++) begin
            int hi;
            hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
            for (int k = 0; k < NR; k++) t_rd[k] = $urandom_range(0, hi);
            for (int j = 0; j < NW; j++) begin
                t_we[j] = ($urandom_range(0, 2) == 0);
                t_wi[j] = $urandom_range(0, hi);
                t_wd[j] = $urandom;
            end
            t_ae = ($urandom_range(0, 1) == 0);
            t_ai = $urandom_range(0, hi);
            t_fl = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end

        // Build up state, then reset between edges with writes still driven
        idle();
        t_ae = 1'b1; t_ai = 7;
        t_we[0] = 1'b1; t_wi[0] = 5; t_wd[0] = 32'hCAFE_F00D;
        set_rd(2, 5, 7, 9);
        cycle("pre_rst");
        t_ai = 9;
        t_we[0] = 1'b1; t_wi[0] = 2; t_wd[0] = 32'hBAD0_0001;
        apply();
        #1;
        rst = 1'b1; m_rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        $display("txn %-12s rst asserted between edges", "async_rst");
        idle();
        apply();
        #1;
        rst = 1'b0; m_rst = 1'b0;
        @(posedge clk);
        #1;
        cycle("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the successor to the single-issue 2R1W regfile in the backend. It adds configurable read/write port counts, an asynchronous reset that restores architectural reset values, and an integrated per-register pending scoreboard. Issue uses the scoreboard to detect outstanding producers. It sits between decode/issue (read, alloc) and writeback (write).

Parameters:
XLEN, 32, register data width in bits
NUM_REGS, 32, number of architectural registers; power of two, at least 2
NUM_READ, 4, number of read ports
NUM_WRITE, 2, number of write ports; the higher port index has higher priority
SP_INDEX, 2, register loaded with SP_RESET on reset
SP_RESET, 32'h02000000, stack pointer reset value
AW, $clog2(NUM_REGS), derived index width; not overridable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rd_index  in  NUM_READ*AW  packed read indices, port k at [k*AW +: AW]
rd_data  out  NUM_READ*XLEN  packed read data
rd_ready  out  NUM_READ  1 = no outstanding producer for port k's register
wr_en  in  NUM_WRITE  per-port write enable
wr_index  in  NUM_WRITE*AW  packed write indices
wr_data  in  NUM_WRITE*XLEN  packed write data
alloc_en  in  1  mark register alloc_index pending (instruction issued)
alloc_index  in  AW  destination register being allocated
flush  in  1  clear all pending bits (pipeline flush)
busy_vec  out  NUM_REGS  current pending bits, for debug and issue

Behaviour:
- Reset (async, rst=1): all registers 0 except SP_INDEX = SP_RESET; all pending bits 0. Outputs during reset: rd_data = reset contents, rd_ready all 1, busy_vec 0. Writes, allocs and flushes are ignored while rst=1.
- Register 0 reads as 0, is never written or marked pending, and always reports rd_ready=1.
- Write (clk edge): each wr_en[j] with wr_index[j]!=0 updates the register. When several ports target the same register, the highest j wins.
- Read (combinational, zero latency), per port k:
  - index 0 -> 0.
  - Otherwise, the highest j with wr_en[j] and a matching index -> wr_data[j] (write-through forwarding).
  - Otherwise, the stored value.
- Scoreboard (clk edge), evaluated in this order (later steps win):
  1. Each active write clears the pending bit of its register.
  2. alloc_en with alloc_index!=0 sets the pending bit. A new producer overrides a same-cycle write-clear.
  3. flush clears all pending bits, overriding alloc in the same cycle.
- rd_ready[k] = !pending[idx] OR (a same-cycle write matches idx). This is consistent with forwarded data. A same-cycle alloc does not affect rd_ready until the next cycle.
- busy_vec reflects the registered pending bits only, with no same-cycle bypass.
- Allocating a register that is already pending is legal; the bit stays set (single-bit scoreboard, no count).
- Indices are full AW width, so no out-of-range case exists.
- rst asserted mid-operation: contents and scoreboard reset immediately, independent of clk.

Decomposition:
- Shared package (rf_pkg): XLEN, NUM_REGS, the AW derivation, SP_INDEX/SP_RESET constants, and the packed-port slice helper. Frontend and backend share these.
- One natural sub-module: rf_scoreboard. It holds the pending bits and the alloc/clear/flush priority, and produces busy_vec plus the raw pending lookup for rd_ready. The data array and forwarding mux stay in regfile_mp.

Test Plan:
- Reset: pulse rst with no clock. All read ports return 0, except index 2 -> 32'h02000000. busy_vec=0 and rd_ready=4'hF.
- Write/forward: wr_en=2'b01, wr_index0=5, wr_data0=32'hDEADBEEF, port 0 reading 5. rd_data0=DEADBEEF in the same cycle, and it persists after the edge once wr_en=0.
- Write collision: both ports write reg 7, port0=32'h11 and port1=32'h22. Forwarded and stored value = 32'h22. A write to reg 0 leaves the read at 0.
- Scoreboard:
  - alloc reg 9 -> next cycle busy_vec[9]=1 and rd_ready=0 for a port reading 9.
  - A write to 9 in a later cycle -> rd_ready=1 that same cycle and busy_vec[9]=0 after the edge.
  - Alloc and write of 9 in the same cycle -> busy_vec[9]=1 afterwards.
- Flush: set regs 3, 4 and 5 pending, then flush with alloc_en=1, alloc_index=6. Next cycle busy_vec=0.
- Async reset mid-run: assert rst between clock edges after writes and allocs. Contents and pending clear immediately, and SP reads 32'h02000000.
